// File: rtl/bandai2003_pkg.sv
// Shared constants and state encoding for the Bandai 2003 unlock host.
package bandai2003_pkg;

    localparam logic [7:0]  ADDR_ACK        = 8'h5A;
    localparam logic [7:0]  ADDR_NAK        = 8'hA5;
    localparam int          FRAME_DATA_BITS = 16;
    localparam logic [15:0] EXPECT_WORD     = 16'h28A0;

    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0]  ERR_TRAILER  = 2'b10;
    localparam logic [1:0]  ERR_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_SEND_ACK      = 3'd1,
        ST_SEND_NAK      = 3'd2,
        ST_WAIT_START    = 3'd3,
        ST_SHIFT         = 3'd4,
        ST_CHECK_TRAILER = 3'd5,
        ST_FINISH        = 3'd6
    } state_t;

endpackage

// File: rtl/bandai2003_unlock_host_sdeser.sv
// LSB-first serial-to-parallel shifter; done strobes combinationally on the last bit's enable.
module bandai2003_unlock_host_sdeser
    import bandai2003_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic                       din,
    output logic [FRAME_DATA_BITS-1:0] data,
    output logic                       done
);

    localparam int CNT_W = $clog2(FRAME_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DATA_BITS - 1);

    logic [CNT_W-1:0] bit_cnt;

    // Shift register and bit counter; counter wraps to zero after the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            data    <= {din, data[FRAME_DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
        end else begin
            data    <= data;
            bit_cnt <= bit_cnt;
        end
    end

    assign done = en && (bit_cnt == CNT_LAST);

endmodule

// File: rtl/bandai2003_unlock_host.sv
// Console-side unlock initiator and frame receiver for the Bandai 2003 mapper.
// Optional BANDAI2003_AUTH_CHECK_EN: compare the word against EXPECT_WORD and drive SYSCTRL_SET.
module bandai2003_unlock_host
    import bandai2003_pkg::*;
#(
    parameter int         TIMEOUT   = 8,
    parameter logic [7:0] IDLE_ADDR = 8'h00
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SO_IN,
    output logic [7:0]  ADDR,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] DATA,
    output logic        VALID,
    output logic        ERR,
`ifdef BANDAI2003_AUTH_CHECK_EN
    output logic [1:0]  ERR_CODE,
    output logic        SYSCTRL_SET
`else
    output logic [1:0]  ERR_CODE
`endif
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state, state_nx;
    logic [7:0] tmo_cnt, tmo_nx;
    logic       valid_nx, err_nx;
    logic [1:0] code_nx;
    logic [7:0] addr_nx;
    logic       busy_nx, done_nx;
    logic       start_ok, deser_en, deser_done;
`ifdef BANDAI2003_AUTH_CHECK_EN
    logic       sysctrl_nx;
`endif

    assign start_ok = (state == ST_IDLE) && START;
    assign deser_en = (state == ST_SHIFT);

    bandai2003_unlock_host_sdeser u_sdeser (
        .clk  (CLK),
        .rst  (RST),
        .clr  (start_ok),
        .en   (deser_en),
        .din  (SO_IN),
        .data (DATA),
        .done (deser_done)
    );

    // Next-state, status and output-register decode.
    always_comb begin
        state_nx = state;
        tmo_nx   = tmo_cnt;
        valid_nx = VALID;
        err_nx   = ERR;
        code_nx  = ERR_CODE;
`ifdef BANDAI2003_AUTH_CHECK_EN
        sysctrl_nx = SYSCTRL_SET;
`endif
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nx = ST_SEND_ACK;
                    tmo_nx   = 8'd0;
                    valid_nx = 1'b0;
                    err_nx   = 1'b0;
                    code_nx  = ERR_NONE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SEND_ACK: state_nx = ST_SEND_NAK;
            ST_SEND_NAK: begin
                state_nx = ST_WAIT_START;
                tmo_nx   = 8'd0;
            end
            ST_WAIT_START: begin
                if (!SO_IN) begin
                    state_nx = ST_SHIFT;
                    tmo_nx   = 8'd0;
                end else if (tmo_cnt + 8'd1 == TIMEOUT_C) begin
                    state_nx = ST_FINISH;
                    tmo_nx   = 8'd0;
                    err_nx   = 1'b1;
                    code_nx  = ERR_TIMEOUT;
                end else begin
                    tmo_nx   = tmo_cnt + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (deser_done) begin
                    state_nx = ST_CHECK_TRAILER;
                end else begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_CHECK_TRAILER: begin
                state_nx = ST_FINISH;
                if (SO_IN) begin
                    err_nx  = 1'b1;
                    code_nx = ERR_TRAILER;
`ifdef BANDAI2003_AUTH_CHECK_EN
                end else if (DATA != EXPECT_WORD) begin
                    err_nx  = 1'b1;
                    code_nx = ERR_MISMATCH;
                end else begin
                    valid_nx   = 1'b1;
                    sysctrl_nx = 1'b1;
                end
`else
                end else begin
                    valid_nx = 1'b1;
                end
`endif
            end
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase

        // Outputs are registered from the upcoming state so they align with it.
        case (state_nx)
            ST_SEND_ACK: addr_nx = ADDR_ACK;
            ST_SEND_NAK: addr_nx = ADDR_NAK;
            default:     addr_nx = IDLE_ADDR;
        endcase
        busy_nx = (state_nx != ST_IDLE) && (state_nx != ST_FINISH);
        done_nx = (state_nx == ST_FINISH);
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            tmo_cnt  <= 8'd0;
            ADDR     <= IDLE_ADDR;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            VALID    <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= ERR_NONE;
`ifdef BANDAI2003_AUTH_CHECK_EN
            SYSCTRL_SET <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            tmo_cnt  <= tmo_nx;
            ADDR     <= addr_nx;
            BUSY     <= busy_nx;
            DONE     <= done_nx;
            VALID    <= valid_nx;
            ERR      <= err_nx;
            ERR_CODE <= code_nx;
`ifdef BANDAI2003_AUTH_CHECK_EN
            SYSCTRL_SET <= sysctrl_nx;
`endif
        end
    end

endmodule

// File: tb/tb_bandai2003_unlock_host.sv
// Directed self-checking bench for bandai2003_unlock_host (default and BANDAI2003_AUTH_CHECK_EN builds).
module tb_bandai2003_unlock_host;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        SO_IN;
    logic [7:0]  ADDR;
    logic        BUSY;
    logic        DONE;
    logic [15:0] DATA;
    logic        VALID;
    logic        ERR;
    logic [1:0]  ERR_CODE;
`ifdef BANDAI2003_AUTH_CHECK_EN
    logic        SYSCTRL_SET;
    localparam bit AUTH = 1'b1;
`else
    localparam bit AUTH = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    bandai2003_unlock_host #(.TIMEOUT(8), .IDLE_ADDR(8'h00)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .SO_IN    (SO_IN),
        .ADDR     (ADDR),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DATA     (DATA),
        .VALID    (VALID),
        .ERR      (ERR),
`ifdef BANDAI2003_AUTH_CHECK_EN
        .ERR_CODE (ERR_CODE),
        .SYSCTRL_SET (SYSCTRL_SET)
`else
        .ERR_CODE (ERR_CODE)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic so);
        START = st;
        SO_IN = so;
        @(posedge CLK);
        #1;
    endtask

    // One full unlock run. DONE is expected in the 22nd cycle counting the
    // START cycle as the first, i.e. 20 edges after the edge that samples START.
    task automatic run_frame(input string tag, input logic [15:0] word,
                             input logic trailer, input logic start_mid);
        int   done_at;
        logic so;
        logic ok;
        logic [1:0] code;
        done_at = -1;
        step(1'b1, 1'b1);
        check({tag, " addr_ack"}, {8'h00, ADDR}, 16'h005A);
        check({tag, " busy"}, {15'd0, BUSY}, 16'd1);
        for (int k = 1; k <= 20; k++) begin
            if (k <= 2)       so = 1'b1;
            else if (k == 3)  so = 1'b0;
            else if (k <= 19) so = word[k-4];
            else              so = trailer;
            step(start_mid && (k == 10), so);
            if (DONE === 1'b1 && done_at < 0) done_at = k;
            if (k == 1) check({tag, " addr_nak"}, {8'h00, ADDR}, 16'h00A5);
            if (k == 2) check({tag, " addr_idle"}, {8'h00, ADDR}, 16'h0000);
        end
        ok   = !trailer && (!AUTH || word == 16'h28A0);
        code = trailer ? 2'b10 : (ok ? 2'b00 : 2'b11);
        check({tag, " latency"}, 16'(done_at), 16'd20);
        check({tag, " done_busy"}, {14'd0, DONE, BUSY}, 16'b10);
        check({tag, " data"}, DATA, word);
        check({tag, " valid_err"}, {14'd0, VALID, ERR}, {14'd0, ok, !ok});
        check({tag, " err_code"}, {14'd0, ERR_CODE}, {14'd0, code});
        step(1'b0, 1'b1);
        check({tag, " done_pulse"}, {14'd0, DONE, BUSY}, 16'b00);
        check({tag, " data_held"}, DATA, word);
    endtask

    initial begin
        int done_at;
        RST   = 1'b1;
        START = 1'b0;
        SO_IN = 1'b1;
        #12;
        check("reset_addr", {8'h00, ADDR}, 16'h0000);
        check("reset_flags", {12'd0, BUSY, DONE, VALID, ERR}, 16'd0);
        check("reset_data", DATA, 16'h0000);
        check("reset_code", {14'd0, ERR_CODE}, 16'd0);
        @(negedge CLK);
        RST = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Nominal unlock with an extra START dropped into the SHIFT phase.
        run_frame("nominal", 16'h28A0, 1'b0, 1'b1);
`ifdef BANDAI2003_AUTH_CHECK_EN
        check("sysctrl_set", {15'd0, SYSCTRL_SET}, 16'd1);
`endif

        // Mapper is now locked: the line stays high and the start bit times out.
        done_at = -1;
        step(1'b1, 1'b1);
        check("tmo_valid_cleared", {14'd0, VALID, ERR}, 16'b00);
        for (int k = 1; k <= 40; k++) begin
            if (done_at < 0) begin
                step(1'b0, 1'b1);
                if (DONE === 1'b1) done_at = k;
            end
        end
        check("tmo_latency", 16'(done_at), 16'd10);
        check("tmo_valid_err", {14'd0, VALID, ERR}, 16'b01);
        check("tmo_code", {14'd0, ERR_CODE}, 16'd1);
        step(1'b0, 1'b1);

        run_frame("bad_trailer", 16'h1234, 1'b1, 1'b0);
        run_frame("other_word", 16'h5A3C, 1'b0, 1'b0);

        // Abort after 7 data bits.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1);
        RST = 1'b1;
        #2;
        check("abort_addr", {8'h00, ADDR}, 16'h0000);
        check("abort_flags", {12'd0, BUSY, DONE, VALID, ERR}, 16'd0);
        check("abort_data", DATA, 16'h0000);
`ifdef BANDAI2003_AUTH_CHECK_EN
        check("abort_sysctrl", {15'd0, SYSCTRL_SET}, 16'd0);
`endif
        step(1'b0, 1'b1);
        RST = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        check("abort_idle", {12'd0, BUSY, DONE, VALID, ERR}, 16'd0);

`ifdef BANDAI2003_AUTH_CHECK_EN
        run_frame("auth_mismatch", 16'h28A1, 1'b0, 1'b0);
        check("auth_mismatch_sysctrl", {15'd0, SYSCTRL_SET}, 16'd0);
`endif
        run_frame("after_reset", 16'h28A0, 1'b0, 1'b0);
`ifdef BANDAI2003_AUTH_CHECK_EN
        check("auth_sysctrl", {15'd0, SYSCTRL_SET}, 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
